// File: rtl/cluster_pkg.sv
// Shared constants and types for the cluster address encoder.
// Geometry of the 768-bit partition vector and the packed cluster list.
package cluster_pkg;

  localparam int MXSEGS     = 12;
  localparam int SEGSIZE    = 64;
  localparam int MXADRB     = 10;
  localparam int MXCLUSTERS = 8;
  localparam int MXBITS     = MXSEGS * SEGSIZE;
  localparam int SEGADRB    = 6;
  localparam int SEGIDXB    = MXADRB - SEGADRB;
  localparam int PASSB      = 3;
  localparam int SLOTW      = MXADRB + 1;
  localparam int CLUSTERW   = MXCLUSTERS * SLOTW;

  localparam logic [MXADRB-1:0] ADR_INVALID = '0;
  localparam logic [PASSB-1:0]  LAST_PASS   = PASSB'(MXCLUSTERS - 1);

  typedef logic [SLOTW-1:0] slot_t;

  function automatic slot_t mk_slot(
    input logic              vld,
    input logic [MXADRB-1:0] adr
  );
    return {vld, adr};
  endfunction

endpackage

// File: rtl/cluster_address_encoder_if.sv
// Bus between the truncator, the encoder and the packet formatter.
// master: upstream/driver side, slave: the encoder itself.
interface cluster_address_encoder_if;
  import cluster_pkg::*;

  logic [PASSB-1:0]    pass;
  logic [MXBITS-1:0]   vpfs_in;
  logic [MXADRB-1:0]   adr_out;
  logic                vld_out;
  logic [PASSB-1:0]    pass_out;
  logic [CLUSTERW-1:0] clusters_out;
  logic                frame_strobe;
  logic                overflow;

  modport master (
    output pass,
    output vpfs_in,
    input  adr_out,
    input  vld_out,
    input  pass_out,
    input  clusters_out,
    input  frame_strobe,
    input  overflow
  );

  modport slave (
    input  pass,
    input  vpfs_in,
    output adr_out,
    output vld_out,
    output pass_out,
    output clusters_out,
    output frame_strobe,
    output overflow
  );

endinterface

// File: rtl/priority_encoder64.sv
// 64-bit lowest-set-bit encoder with valid and multiple-hit flags.
// Purely combinational; the caller registers the result.
module priority_encoder64 (
  input  logic [63:0] seg_i,
  output logic        vld_o,
  output logic [5:0]  adr_o,
  output logic        multi_o
);

  always_comb begin
    adr_o = '0;
    for (int i = 63; i >= 0; i--) begin
      if (seg_i[i]) adr_o = 6'(i);
    end
  end

  assign vld_o   = |seg_i;
  assign multi_o = |(seg_i & (seg_i - 64'd1));

endmodule

// File: rtl/cluster_address_encoder.sv
// Two-stage lowest-set-bit encoder over the truncated S-bit vector,
// plus a per-frame collector building the packed cluster list.
module cluster_address_encoder
  import cluster_pkg::*;
(
  input logic                      clock,
  input logic                      reset,
  cluster_address_encoder_if.slave io
);

  logic [MXSEGS-1:0]              enc_vld;
  logic [MXSEGS-1:0]              enc_multi;
  logic [MXSEGS-1:0][SEGADRB-1:0] enc_adr;

  for (genvar g = 0; g < MXSEGS; g++) begin : g_seg
    priority_encoder64 u_pe (
      .seg_i   (io.vpfs_in[g*SEGSIZE +: SEGSIZE]),
      .vld_o   (enc_vld[g]),
      .adr_o   (enc_adr[g]),
      .multi_o (enc_multi[g])
    );
  end

  logic [MXSEGS-1:0]              s1_vld_q;
  logic [MXSEGS-1:0]              s1_multi_q;
  logic [MXSEGS-1:0][SEGADRB-1:0] s1_adr_q;
  logic [PASSB-1:0]               s1_pass_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_vld_q   <= '0;
      s1_multi_q <= '0;
      s1_adr_q   <= '0;
      s1_pass_q  <= '0;
    end else begin
      s1_vld_q   <= enc_vld;
      s1_multi_q <= enc_multi;
      s1_adr_q   <= enc_adr;
      s1_pass_q  <= io.pass;
    end
  end

  logic [MXADRB-1:0] adr_d, adr_q;
  logic              vld_d, vld_q;
  logic              multi_d, multi_q;
  logic [PASSB-1:0]  pass_q;
  logic              sel_multi;

  // Lowest valid segment wins; its index forms the upper address bits.
  always_comb begin
    adr_d     = ADR_INVALID;
    sel_multi = 1'b0;
    for (int s = MXSEGS - 1; s >= 0; s--) begin
      if (s1_vld_q[s]) begin
        adr_d     = {SEGIDXB'(s), s1_adr_q[s]};
        sel_multi = s1_multi_q[s];
      end
    end
    vld_d   = |s1_vld_q;
    multi_d = sel_multi
            | (|(s1_vld_q & (s1_vld_q - MXSEGS'(1))));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      adr_q   <= '0;
      vld_q   <= 1'b0;
      multi_q <= 1'b0;
      pass_q  <= '0;
    end else begin
      adr_q   <= adr_d;
      vld_q   <= vld_d;
      multi_q <= multi_d;
      pass_q  <= s1_pass_q;
    end
  end

  slot_t [MXCLUSTERS-1:0] shadow_d, shadow_q;
  slot_t [MXCLUSTERS-1:0] clusters_d, clusters_q;
  logic                   strobe_d, strobe_q;
  logic                   ovf_d, ovf_q;
  slot_t                  cur;

  // Last pass closes the frame: publish, then start a clean shadow.
  always_comb begin
    cur        = mk_slot(vld_q, adr_q);
    shadow_d   = shadow_q;
    clusters_d = clusters_q;
    strobe_d   = 1'b0;
    ovf_d      = ovf_q;
    if (pass_q == LAST_PASS) begin
      clusters_d                 = shadow_q;
      clusters_d[MXCLUSTERS-1]   = cur;
      strobe_d                   = 1'b1;
      ovf_d                      = multi_q;
      shadow_d                   = '0;
    end else begin
      shadow_d[pass_q] = cur;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      shadow_q   <= '0;
      clusters_q <= '0;
      strobe_q   <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      clusters_q <= clusters_d;
      strobe_q   <= strobe_d;
      ovf_q      <= ovf_d;
    end
  end

  assign io.adr_out      = adr_q;
  assign io.vld_out      = vld_q;
  assign io.pass_out     = pass_q;
  assign io.clusters_out = clusters_q;
  assign io.frame_strobe = strobe_q;
  assign io.overflow     = ovf_q;

endmodule
